// File: rtl/line_buffer_7x7_stream_pkg.sv
`default_nettype none
// ============================================================================
// Module   : line_buffer_7x7_stream_pkg
// Brief    : Shared FSM encoding, window constants and line-slot helper for
//            the 7x7 row-assembly line buffer.
// Revision : 1.0 - initial release
// ============================================================================
package line_buffer_7x7_stream_pkg;

  // FSM encoding (2 bits)
  localparam logic [1:0] ST_IDLE   = 2'd0;
  localparam logic [1:0] ST_FILL   = 2'd1;
  localparam logic [1:0] ST_STREAM = 2'd2;
  localparam logic [1:0] ST_DONE   = 2'd3;

  // Window geometry: seven taps, six of them come from stored lines
  localparam int WIN   = 7;
  localparam int LINES = WIN - 1;
  localparam int PIX_W = 8;
  localparam int PTR_W = 3;

  localparam logic [PTR_W:0] LINES_P = LINES[PTR_W:0];

  // (base + k) mod LINES for base, k in 0..LINES-1, kept at 3-bit width
  function automatic logic [PTR_W-1:0] slot_sel(input logic [PTR_W-1:0] base,
                                                input logic [PTR_W-1:0] k);
    logic [PTR_W:0] sum;
    sum = {1'b0, base} + {1'b0, k};
    if (sum >= LINES_P) begin
      sum = sum - LINES_P;
    end
    return sum[PTR_W-1:0];
  endfunction

endpackage
`default_nettype wire

// File: rtl/line_buffer_7x7_stream_line_ram_1rw.sv
`default_nettype none
// ============================================================================
// Module   : line_ram_1rw
// Brief    : Single-port line memory, one address per cycle, registered read
//            that returns the old contents when the same address is written.
// Revision : 1.0 - initial release
// ============================================================================
module line_ram_1rw
  import line_buffer_7x7_stream_pkg::*;
#(
  parameter int   DEPTH = 9,
  parameter int   WIDTH = PIX_W,
  localparam int  AW    = $clog2(DEPTH)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             en,
  input  logic             we,
  input  logic [AW-1:0]    addr,
  input  logic [WIDTH-1:0] wdata,
  output logic [WIDTH-1:0] rdata
);

  logic [WIDTH-1:0] mem [DEPTH];

  // Storage array: written on enabled write cycles, never reset
  always_ff @(posedge clk) begin
    if (en && we) begin
      mem[addr] <= wdata;
    end
  end

  // Read register: samples pre-write contents, cleared by reset so taps read 0
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rdata <= '0;
    end else if (en) begin
      rdata <= mem[addr];
    end
  end

endmodule
`default_nettype wire

// File: rtl/line_buffer_7x7_stream.sv
`default_nettype none
// ============================================================================
// Module   : line_buffer_7x7_stream
// Brief    : Raster-stream row assembler. Keeps the six most recent lines in
//            circular line memories and emits one 7-pixel column per accepted
//            pixel once six lines are buffered (S1 = oldest row).
// Revision : 1.0 - initial release
// ============================================================================
module line_buffer_7x7_stream
  import line_buffer_7x7_stream_pkg::*;
#(
  parameter int  COLS = 9,
  parameter int  ROWS = 9,
  localparam int CW   = $clog2(COLS),
  localparam int RW   = $clog2(ROWS)
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          valid_i,
  input  logic [7:0]    data_i,
  output logic [7:0]    S1_o,
  output logic [7:0]    S2_o,
  output logic [7:0]    S3_o,
  output logic [7:0]    S4_o,
  output logic [7:0]    S5_o,
  output logic [7:0]    S6_o,
  output logic [7:0]    S7_o,
  output logic          valid_o,
  output logic [CW-1:0] col_o,
  output logic [RW-1:0] row_o,
  output logic          done_o
);

  logic [1:0]       state;
  logic [CW-1:0]    col;
  logic [RW-1:0]    row;
  logic [PTR_W-1:0] oldest_ptr;
  logic [PTR_W-1:0] rd_ptr;
  logic             accept;
  logic             col_last;
  logic             row_last;
  logic             fill_last;
  logic             frame_last;
  logic [PIX_W-1:0] ram_q [LINES];

  // Accept/boundary decode; the DONE cycle swallows any incoming pixel
  always_comb begin
    accept     = valid_i && (state != ST_DONE);
    col_last   = (col == CW'(COLS - 1));
    row_last   = (row == RW'(ROWS - 1));
    fill_last  = col_last && (row == RW'(LINES - 1));
    frame_last = col_last && row_last;
  end

  // Frame FSM: IDLE -> FILL (rows 0..5) -> STREAM -> DONE -> IDLE
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= ST_IDLE;
    end else begin
      case (state)
        ST_IDLE:   if (accept) state <= ST_FILL;
        ST_FILL:   if (accept && fill_last) state <= ST_STREAM;
        ST_STREAM: if (accept && frame_last) state <= ST_DONE;
        ST_DONE:   state <= ST_IDLE;
        default:   state <= ST_IDLE;
      endcase
    end
  end

  // Column/row counters and oldest-line pointer; cleared in DONE
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      col        <= '0;
      row        <= '0;
      oldest_ptr <= '0;
    end else if (state == ST_DONE) begin
      col        <= '0;
      row        <= '0;
      oldest_ptr <= '0;
    end else if (accept) begin
      if (col_last) begin
        col        <= '0;
        row        <= row_last ? '0 : row + RW'(1);
        oldest_ptr <= slot_sel(oldest_ptr, 3'd1);
      end else begin
        col <= col + CW'(1);
      end
    end
  end

  // Six line slots; all are read at col, only the oldest slot is rewritten
  generate
    for (genvar i = 0; i < LINES; i++) begin : g_lines
      line_ram_1rw #(
        .DEPTH (COLS),
        .WIDTH (PIX_W)
      ) u_ram (
        .clk   (clk),
        .rst_n (rst_n),
        .en    (accept),
        .we    (oldest_ptr == PTR_W'(i)),
        .addr  (col),
        .wdata (data_i),
        .rdata (ram_q[i])
      );
    end
  endgenerate

  // Registered framing, newest tap and the slot pointer used for this read
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      valid_o <= 1'b0;
      done_o  <= 1'b0;
      col_o   <= '0;
      row_o   <= '0;
      S7_o    <= '0;
      rd_ptr  <= '0;
    end else begin
      valid_o <= accept && (state == ST_STREAM);
      done_o  <= accept && (state == ST_STREAM) && frame_last;
      if (accept) begin
        col_o  <= col;
        row_o  <= row;
        S7_o   <= data_i;
        rd_ptr <= oldest_ptr;
      end
    end
  end

  // Oldest-first tap ordering through the pointer captured with the read
  always_comb begin
    S1_o = ram_q[slot_sel(rd_ptr, 3'd0)];
    S2_o = ram_q[slot_sel(rd_ptr, 3'd1)];
    S3_o = ram_q[slot_sel(rd_ptr, 3'd2)];
    S4_o = ram_q[slot_sel(rd_ptr, 3'd3)];
    S5_o = ram_q[slot_sel(rd_ptr, 3'd4)];
    S6_o = ram_q[slot_sel(rd_ptr, 3'd5)];
  end

endmodule
`default_nettype wire

// File: tb/tb_line_buffer_7x7_stream.sv
`default_nettype none
// ============================================================================
// Module   : tb_line_buffer_7x7_stream
// Brief    : Directed bench for line_buffer_7x7_stream, COLS = ROWS = 9,
//            pixel = row*16 + col (second frame inverted).
// Revision : 1.0 - initial release
// ============================================================================
module tb_line_buffer_7x7_stream;
  import line_buffer_7x7_stream_pkg::*;

  localparam int COLS = 9;
  localparam int ROWS = 9;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       valid_i = 1'b0;
  logic [7:0] data_i = 8'h00;
  logic [7:0] S1_o, S2_o, S3_o, S4_o, S5_o, S6_o, S7_o;
  logic       valid_o, done_o;
  logic [3:0] col_o;
  logic [3:0] row_o;

  int n_cmp = 0;
  int n_bad = 0;
  int n_valid = 0;

  line_buffer_7x7_stream #(.COLS(COLS), .ROWS(ROWS)) dut (
    .clk(clk), .rst_n(rst_n), .valid_i(valid_i), .data_i(data_i),
    .S1_o(S1_o), .S2_o(S2_o), .S3_o(S3_o), .S4_o(S4_o), .S5_o(S5_o),
    .S6_o(S6_o), .S7_o(S7_o), .valid_o(valid_o), .col_o(col_o),
    .row_o(row_o), .done_o(done_o)
  );

  always #5 clk = ~clk;

  function automatic logic [7:0] pix(input int f, input int r, input int c);
    return (f == 0) ? 8'(r * 16 + c) : 8'(255 - (r * 16 + c));
  endfunction

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic logic [55:0] taps();
    return {S1_o, S2_o, S3_o, S4_o, S5_o, S6_o, S7_o};
  endfunction

  // One accepted pixel, then check the registered result of that edge
  task automatic pixel_step(input int f, input int r, input int c);
    valid_i = 1'b1;
    data_i  = pix(f, r, c);
    @(posedge clk); #1;
    valid_i = 1'b0;
    if (r >= 6) begin
      n_valid++;
      chk("valid_on", 64'(valid_o), 64'd1);
      chk("taps", 64'(taps()), 64'({pix(f, r-6, c), pix(f, r-5, c), pix(f, r-4, c),
                                    pix(f, r-3, c), pix(f, r-2, c), pix(f, r-1, c),
                                    pix(f, r, c)}));
      chk("col_row", 64'({col_o, row_o}), 64'({4'(c), 4'(r)}));
    end else begin
      chk("valid_off", 64'(valid_o), 64'd0);
    end
    chk("done", 64'(done_o), 64'((r == ROWS-1) && (c == COLS-1)));
    if (f == 0 && r == 6 && c == 0) chk("first_taps_f0", 64'(taps()), 64'h00102030405060);
    if (f == 0 && r == 8 && c == 0) begin
      chk("row8_taps", 64'(taps()), 64'h20304050607080);
      chk("row8_slot", 64'(dut.rd_ptr), 64'd2);
    end
    if (f == 0 && r == 8 && c == 8) chk("last_taps_f0", 64'(taps()), 64'h28384858687888);
    if (f == 1 && r == 6 && c == 0) chk("first_taps_f1", 64'(taps()), 64'hFFEFDFCFBFAF9F);
  endtask

  task automatic gap_step();
    valid_i = 1'b0;
    data_i  = 8'($urandom);
    @(posedge clk); #1;
    chk("gap_valid", 64'({valid_o, done_o}), 64'd0);
  endtask

  // Cycle after the last pixel: DONE, an offered pixel here must be dropped
  task automatic done_step(input logic junk);
    valid_i = junk;
    data_i  = 8'hAA;
    @(posedge clk); #1;
    valid_i = 1'b0;
    chk("done_cycle", 64'({valid_o, done_o}), 64'd0);
  endtask

  task automatic run_frame(input int f, input bit gaps, input int npix);
    int cyc;
    cyc = 0;
    n_valid = 0;
    for (int p = 0; p < npix; p++) begin
      if (gaps && (cyc % 3 == 2)) begin
        gap_step();
        cyc++;
      end
      pixel_step(f, p / COLS, p % COLS);
      cyc++;
    end
    if (npix == ROWS * COLS) chk("valid_count", 64'(n_valid), 64'd27);
  endtask

  initial begin
    // Power-on reset
    repeat (2) @(posedge clk);
    #1;
    chk("reset_taps", 64'(taps()), 64'd0);
    chk("reset_ctrl", 64'({valid_o, done_o, col_o, row_o}), 64'd0);
    rst_n = 1'b1;
    gap_step();

    // Continuous frame
    run_frame(0, 1'b0, ROWS * COLS);
    done_step(1'b0);

    // Gapped frame, then a pixel offered in the DONE cycle
    run_frame(0, 1'b1, ROWS * COLS);
    done_step(1'b1);

    // Back-to-back inverted frame
    run_frame(1, 1'b0, ROWS * COLS);
    done_step(1'b0);

    // Asynchronous reset in the middle of row 7, then a clean frame
    run_frame(0, 1'b0, 7 * COLS + 3);
    rst_n = 1'b0;
    #2;
    chk("async_rst_taps", 64'(taps()), 64'd0);
    chk("async_rst_ctrl", 64'({valid_o, done_o, col_o, row_o}), 64'd0);
    valid_i = 1'b1;
    data_i  = 8'h55;
    @(posedge clk); #1;
    valid_i = 1'b0;
    chk("held_rst_ctrl", 64'({valid_o, done_o, col_o, row_o}), 64'd0);
    chk("held_rst_state", 64'(dut.state), 64'(ST_IDLE));
    rst_n = 1'b1;
    run_frame(0, 1'b0, ROWS * COLS);
    done_step(1'b0);

    // Lone pixel then silence: stays in FILL, nothing emitted
    pixel_step(0, 0, 0);
    for (int i = 0; i < 20; i++) gap_step();
    chk("lone_state", 64'(dut.state), 64'(ST_FILL));

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
`default_nettype wire
